// File: rtl/host_cmd_master.sv
// host_cmd_master: host-side initiator for the 16-bit cmd_cfg command protocol.
// Sends a latched command as two UART bytes (high then low). It then collects
// either one response byte or ENTRIES dump bytes.
// Optional build macro: HCM_TIMEOUT_EN. When it is defined, each response byte
// wait is bounded to TIMEOUT cycles.
module host_cmd_master #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9,
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     cmd,
    input  logic            snd_cmd,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    input  logic [7:0]      rx_data,
    input  logic            rdy,
    output logic            clr_rdy,
    output logic [7:0]      resp,
    output logic            resp_vld,
    output logic [LOG2-1:0] dump_idx,
    output logic            busy,
    output logic            cmd_cmplt,
    output logic            nak,
    output logic            timeout
);

    typedef enum logic [2:0] {
        IDLE,
        TX_HI,
        WAIT_HI,
        TX_LO,
        WAIT_LO,
        RX,
        DONE
    } state_t;

    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);

    state_t          state;
    logic [15:0]     cmd_q;
    logic [LOG2-1:0] byte_cnt;
    logic            is_dump;
    logic            take;

`ifdef HCM_TIMEOUT_EN
    logic [19:0]     tmo_cnt;
    logic            timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign is_dump = (cmd_q[15:14] == 2'b10);

    // rdy stays high until the receiver sees clr_rdy.
    // Skip the cycle in which clr_rdy is already out, so one byte is never taken twice.
    assign take = rdy && !clr_rdy;

    // Command FSM with registered outputs; all pulses default low each cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= '0;
            byte_cnt  <= '0;
            tx_data   <= '0;
            trmt      <= 1'b0;
            clr_rdy   <= 1'b0;
            resp      <= '0;
            resp_vld  <= 1'b0;
            dump_idx  <= '0;
            busy      <= 1'b0;
            cmd_cmplt <= 1'b0;
            nak       <= 1'b0;
`ifdef HCM_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            trmt      <= 1'b0;
            clr_rdy   <= 1'b0;
            resp_vld  <= 1'b0;
            cmd_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    // busy drops one cycle after cmd_cmplt.
                    // A request arriving while it is still high is ignored.
                    busy <= 1'b0;
                    if (snd_cmd && !busy) begin
                        cmd_q   <= cmd;
                        nak     <= 1'b0;
`ifdef HCM_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        busy    <= 1'b1;
                        // The high byte is launched on acceptance.
                        // trmt is therefore visible during TX_HI, one cycle after snd_cmd.
                        tx_data <= cmd[15:8];
                        trmt    <= 1'b1;
                        state   <= TX_HI;
                    end
                end
                TX_HI: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_done) state <= TX_LO;
                end
                TX_LO: begin
                    tx_data <= cmd_q[7:0];
                    trmt    <= 1'b1;
                    state   <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (tx_done) begin
                        byte_cnt <= '0;
`ifdef HCM_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                        state    <= RX;
                    end
                end
                RX: begin
                    if (take) begin
                        clr_rdy  <= 1'b1;
                        resp_vld <= 1'b1;
                        resp     <= rx_data;
                        dump_idx <= byte_cnt;
`ifdef HCM_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                        if (is_dump) begin
                            if (byte_cnt == LAST_IDX) state <= DONE;
                            else byte_cnt <= byte_cnt + LOG2'(1);
                        end else begin
                            nak   <= (rx_data == 8'hEE);
                            state <= DONE;
                        end
                    end
`ifdef HCM_TIMEOUT_EN
                    else if (tmo_cnt == TIMEOUT) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
`endif
                end
                DONE: begin
                    cmd_cmplt <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/host_cmd_master.md
Name: host_cmd_master

Overview:
- Host-side initiator for the 16-bit command protocol answered by cmd_cfg.
- Latches a 16-bit command, serialises it as two bytes (high then low) into a UART transmitter, then collects the response bytes from a UART receiver.
- Response length depends on the command type: one byte, or ENTRIES bytes for a channel dump.
- Used in system benches and on the host FPGA to drive the logic-analyzer core.

Parameters:
- ENTRIES, 384, number of bytes returned by a dump command.
- LOG2, 9, width of the dump byte index; must satisfy 2^LOG2 >= ENTRIES.
- TIMEOUT, 20'hFFFFF, cycles to wait for each response byte (used only with HCM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- cmd  in  16  command; [15:14] opcode: 00 read reg, 01 write reg, 10 dump, 11 reserved.
- snd_cmd  in  1  one-cycle request to send cmd.
- tx_data  out  8  byte to UART transmitter.
- trmt  out  1  one-cycle pulse to start transmission of tx_data.
- tx_done  in  1  transmitter finished the current byte.
- rx_data  in  8  byte from UART receiver.
- rdy  in  1  rx_data valid; stays high until clr_rdy.
- clr_rdy  out  1  one-cycle pulse consuming rx_data.
- resp  out  8  last received response byte.
- resp_vld  out  1  one-cycle pulse per received response byte.
- dump_idx  out  LOG2  index of the current dump byte (0..ENTRIES-1).
- busy  out  1  transaction in progress.
- cmd_cmplt  out  1  one-cycle pulse when the transaction ends.
- nak  out  1  sticky flag: last single-byte response was 8'hEE; cleared on the next accepted snd_cmd.
- timeout  out  1  sticky flag: response wait expired; cleared on the next accepted snd_cmd.

Behaviour:
- All state updates on posedge clk.
- Synchronous active-low reset:
  - FSM returns to IDLE.
  - All outputs are 0: tx_data=8'h00, resp=8'h00, dump_idx=0.
  - Reset asserted mid-transaction aborts it with no cmd_cmplt.
- States and transitions:
  - IDLE: busy=0. On snd_cmd, latch cmd into cmd_q, clear nak/timeout, go TX_HI. busy rises the next cycle.
  - TX_HI: drive tx_data=cmd_q[15:8], pulse trmt for exactly one cycle, go WAIT_HI.
  - WAIT_HI: hold tx_data; on tx_done go TX_LO.
  - TX_LO: drive tx_data=cmd_q[7:0], pulse trmt, go WAIT_LO.
  - WAIT_LO: on tx_done, clear the byte counter and go RX.
  - RX: on rdy, in the same cycle pulse clr_rdy and resp_vld; resp<=rx_data; dump_idx<=byte counter.
    - Opcodes 00, 01, 11: one byte, then go DONE. nak<=(rx_data==8'hEE).
    - Opcode 10: increment the counter. After byte ENTRIES-1 go DONE; otherwise stay in RX.
  - DONE: pulse cmd_cmplt, go IDLE.
- Opcode 11 is still transmitted; the expected response is a single byte (normally 8'hEE).
- Byte-handling rules:
  - A rdy present before RX is not consumed; it is consumed once RX is entered.
  - tx_done outside the WAIT states is ignored.
  - snd_cmd while busy is ignored; cmd_q is unchanged.
- Latency:
  - trmt for the high byte: 1 cycle after snd_cmd.
  - trmt for the low byte: 2 cycles after the first tx_done.
  - cmd_cmplt: 1 cycle after the final resp_vld.
- Counter:
  - LOG2 bits; never exceeds ENTRIES-1; no wrap.
  - For opcode 10, dump_idx on the k-th resp_vld equals k-1.
- Simultaneous rdy and reset: reset wins; clr_rdy=0.

Optional Feature:
- Macro: HCM_TIMEOUT_EN.
- Defined:
  - A 20-bit counter clears on entry to RX and on each consumed byte, and increments every cycle spent in RX.
  - On reaching TIMEOUT, set timeout=1 and go DONE; cmd_cmplt still pulses; remaining dump bytes are abandoned.
- Not defined:
  - No counter logic is generated; timeout is tied to 0.
  - RX waits indefinitely.

Test Plan:
- Write: snd_cmd with cmd=16'h4B55; model tx_done 10 cycles after each trmt; return 8'hA5 -> tx_data 8'h4B then 8'h55, each with a single trmt; resp=8'hA5; nak=0; one cmd_cmplt.
- Read: cmd=16'h0B55; return 8'h55 -> one resp_vld with resp=8'h55; busy falls the cycle after cmd_cmplt.
- Dump: cmd=16'h8100; return bytes 8'h01..8'h80 repeating for 384 bytes -> 384 resp_vld pulses; last dump_idx=383; cmd_cmplt one cycle after the last resp_vld; no 385th clr_rdy.
- NAK and ignore: cmd=16'hC000; return 8'hEE -> nak=1. A snd_cmd during that transaction is ignored. The next snd_cmd clears nak.
- Reset mid-dump: rst_n low after 100 dump bytes -> all outputs 0 next cycle; IDLE; no cmd_cmplt. A fresh write then completes normally.
- HCM_TIMEOUT_EN with TIMEOUT=1000: read with no response -> timeout=1 and cmd_cmplt about 1000 cycles after entering RX. Without the macro, busy stays high.
